// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int MID_TICK           = 8;
  localparam int VOTE_FIRST         = 6;

endpackage

// File: rtl/uart_rx_sync.sv
// rxd 2-flop synchronizer plus the two early vote samples; line_o lags rxd_i by 2 clk.
// vote_o is the 2-of-3 majority of the stored samples and the current line (valid on the decision tick).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd_i,
  input  logic sample_en_i,
  output logic line_o,
  output logic vote_o
);

  logic [1:0] sync_q;
  logic [1:0] smp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      smp_q  <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      if (sample_en_i) begin
        smp_q <= {smp_q[0], sync_q[1]};
      end
    end
  end

  assign line_o = sync_q[1];
  assign vote_o = (smp_q[1] & smp_q[0]) | (smp_q[1] & line_o) | (smp_q[0] & line_o);

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1-style receive framer with mid-bit majority vote; outputs register 1 clk after the stop decision tick.
// One-deep output register on valid/ready: a frame completing while it is held and not accepted is dropped (overrun).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 framing_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [OSW-1:0] OS_MID   = OSW'(MID_TICK);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_V0    = OSW'(VOTE_FIRST);
  localparam logic [OSW-1:0] OS_V1    = OSW'(VOTE_FIRST + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, ovr_q, busy_q;
  logic                 frame_done, frame_bad;
  logic                 line, vote, sample_en;

  assign sample_en = sample_tick && (state_q != IDLE) &&
                     ((os_cnt_q == OS_V0) || (os_cnt_q == OS_V1));

  uart_rx_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd_i       (rxd),
    .sample_en_i (sample_en),
    .line_o      (line),
    .vote_o      (vote)
  );

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    if (sample_tick) begin
      os_cnt_d = os_cnt_q + OSW'(1);
      case (state_q)
        IDLE: begin
          if (!line) state_d = START;
        end
        START: begin
          if (os_cnt_q == OS_MID && vote) begin
            state_d = IDLE;
          end else if (os_cnt_q == OS_LAST) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          if (os_cnt_q == OS_MID) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (os_cnt_q == OS_LAST) begin
            if (bit_cnt_q == BIT_LAST) state_d = STOP;
            else bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch the next start edge.
          if (os_cnt_q == OS_MID) begin
            if (vote) begin
              frame_done = 1'b1;
              state_d    = IDLE;
            end else begin
              frame_bad = 1'b1;
              state_d   = BREAK;
            end
          end
        end
        BREAK: begin
          if (line) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (state_d != state_q) os_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ferr_q    <= frame_bad;
      ovr_q     <= 1'b0;
      busy_q    <= (state_d != IDLE);
      if (frame_done && (!valid_q || ready_i)) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (frame_done) begin
        ovr_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign framing_err_o = ferr_q;
  assign overrun_o     = ovr_q;
  assign busy_o        = busy_q;

endmodule
